// File: rtl/lc3b_types.sv
// ============================================================================
//  Module      : lc3b_types (package)
//  Description : Shared LC-3b memory-system types and constants used by the
//                MSHR / write-combining buffer controller.
//                - lc3b_word          : 16-bit machine word / physical address
//                - lc3b_mpnc_tag      : 11-bit line tag
//                - MSHR_DEPTH         : buffer entry count
//                - MSHR_LINE_OFFSET   : byte-offset bits inside a line
//                - mshr_drain_state_t : head-entry drain sequencer states
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lc3b_types;

   typedef logic [15:0] lc3b_word;
   typedef logic [10:0] lc3b_mpnc_tag;

   localparam int MSHR_DEPTH       = 16;
   localparam int MSHR_LINE_OFFSET = 5;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FILL   = 3'd1,
      LOAD   = 3'd2,
      WB     = 3'd3,
      RETIRE = 3'd4
   } mshr_drain_state_t;

   // Line-aligned physical address of a tagged line.
   function automatic lc3b_word mshr_line_addr(input lc3b_mpnc_tag tag);
      return {tag, {MSHR_LINE_OFFSET{1'b0}}};
   endfunction

endpackage

`default_nettype wire

// File: rtl/mshr_rr_arbiter.sv
// ============================================================================
//  Module      : mshr_rr_arbiter
//  Description : Two-requester round-robin arbiter. A lone requester is
//                granted without touching the preference bit; when both
//                request, the preferred one wins and preference flips.
//  Ports       : clk    in   clock
//                reset  in   asynchronous active-high reset (rr -> port 0)
//                needy  in   [1:0] eligible requesters this cycle
//                grant  out  [1:0] one-hot (or zero) grant
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mshr_rr_arbiter (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] needy,
   output logic [1:0] grant
);

   logic rr_q;
   logic rr_d;

   always_comb begin
      grant = 2'b00;
      rr_d  = rr_q;
      case (needy)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11: begin
            grant = rr_q ? 2'b10 : 2'b01;
            rr_d  = ~rr_q;
         end
         default: grant = 2'b00;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_q <= 1'b0;
      end else begin
         rr_q <= rr_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/mshr_ctrl.sv
// ============================================================================
//  Module      : mshr_ctrl
//  Description : Sequencing controller for the MSHR / write-combining buffer
//                sitting between the split L1 ports (0 = I-side, 1 = D-side)
//                and physical memory. Arbitrates the single allocation path,
//                tracks occupancy and drains the head entry through a
//                fill / write-back / retire sequencer.
//  Ports       : clk, reset           clock, async active-high reset
//                port_req/port_write  per-port request and direction
//                port_resp            per-port completion pulse
//                mshr_full/dirty/waiting/addr_hit/hit/tag  buffer status
//                mshr_load_addr/load_word/load_line/port_index/inc_cur_ptr
//                                     buffer controls
//                pmem_read/write/address, pmem_resp   memory handshake
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mshr_ctrl
   import lc3b_types::*;
#(
   parameter int DEPTH = MSHR_DEPTH,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic        clk,
   input  logic        reset,

   input  logic [1:0]  port_req,
   input  logic [1:0]  port_write,
   output logic [1:0]  port_resp,

   input  logic        mshr_full,
   input  logic        mshr_dirty,
   input  logic        mshr_waiting,
   input  logic [1:0]  mshr_addr_hit,
   input  logic [1:0]  mshr_hit,
   input  logic [10:0] mshr_tag,
   output logic        mshr_load_addr,
   output logic        mshr_load_word,
   output logic        mshr_load_line,
   output logic        mshr_port_index,
   output logic        mshr_inc_cur_ptr,

   output logic        pmem_read,
   output logic        pmem_write,
   output logic [15:0] pmem_address,
   input  logic        pmem_resp
);

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;

   mshr_drain_state_t state_q, state_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic [1:0] wr_need;
   logic [1:0] rd_alloc;
   logic [1:0] blocked;
   logic [1:0] eligible;
   logic [1:0] grant;
   logic       hazard;
   logic       head_locked;
   logic       cnt_inc;
   logic       cnt_dec;

   // ------------------------------------------------------------------
   // Drain sequencer
   // ------------------------------------------------------------------
   always_comb begin
      state_d          = state_q;
      pmem_read        = 1'b0;
      pmem_write       = 1'b0;
      mshr_load_line   = 1'b0;
      mshr_inc_cur_ptr = 1'b0;
      case (state_q)
         IDLE: begin
            if (count_q != CNT_ZERO) begin
               if (mshr_waiting)    state_d = FILL;
               else if (mshr_dirty) state_d = WB;
               else                 state_d = RETIRE;
            end
         end
         FILL: begin
            pmem_read = 1'b1;
            if (pmem_resp) state_d = LOAD;
         end
         LOAD: begin
            // Line returned last cycle is merged into the head entry now.
            mshr_load_line = 1'b1;
            state_d        = mshr_dirty ? WB : RETIRE;
         end
         WB: begin
            pmem_write = 1'b1;
            if (pmem_resp) state_d = RETIRE;
         end
         RETIRE: begin
            mshr_inc_cur_ptr = 1'b1;
            state_d          = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   assign pmem_address = (pmem_read | pmem_write) ? mshr_line_addr(mshr_tag) : 16'h0000;

   // ------------------------------------------------------------------
   // Port eligibility and arbitration
   // ------------------------------------------------------------------
   // The buffer gives load_line / inc_cur_ptr priority over port writes,
   // so no grant is issued while either is active.
   assign hazard      = mshr_load_line | mshr_inc_cur_ptr;
   // While the head line is being written back (or is about to leave), a
   // merge into an existing entry could land in that very line and be lost.
   assign head_locked = (state_q == WB) || (state_q == RETIRE);

   assign wr_need  = port_req & port_write;
   assign rd_alloc = port_req & ~port_write & ~mshr_addr_hit;

   // Anything that needs a fresh entry is held off while the buffer is full.
   assign blocked  = {2{hazard}}
                   | ({2{mshr_full}} & (rd_alloc | (wr_need & ~mshr_addr_hit)))
                   | ({2{head_locked}} & wr_need & mshr_addr_hit);

   assign eligible = (wr_need | rd_alloc) & ~blocked;

   mshr_rr_arbiter u_arb (
      .clk   (clk),
      .reset (reset),
      .needy (eligible),
      .grant (grant)
   );

   assign mshr_load_word  = |(grant & port_write);
   assign mshr_load_addr  = |(grant & ~port_write);
   assign mshr_port_index = grant[1];

   // Writes are posted (ack on grant); reads complete once the word is present.
   assign port_resp = (port_req & ~port_write & mshr_hit) | (grant & port_write);

   // ------------------------------------------------------------------
   // Occupancy counter
   // ------------------------------------------------------------------
   assign cnt_inc = mshr_load_addr | (mshr_load_word & ~mshr_addr_hit[mshr_port_index]);
   assign cnt_dec = mshr_inc_cur_ptr;

   always_comb begin
      count_d = count_q;
      if (cnt_inc && !cnt_dec && (count_q != CNT_MAX)) begin
         count_d = count_q + 1'b1;
      end else if (cnt_dec && !cnt_inc && (count_q != CNT_ZERO)) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mshr_ctrl.sv
// ============================================================================
//  Module      : tb_mshr_ctrl
//  Description : Self-checking bench for mshr_ctrl. A cycle-by-cycle vector
//                table covers read miss, alternating writes, write-hit stalls
//                and load_line hazards; hand sequences cover buffer-full
//                blocking and reset during write-back.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mshr_ctrl;

   localparam logic [10:0] TAG  = 11'h5A3;
   localparam logic [15:0] ADDR = 16'hB460;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  port_req, port_write, port_resp;
   logic        mshr_full, mshr_dirty, mshr_waiting;
   logic [1:0]  mshr_addr_hit, mshr_hit;
   logic [10:0] mshr_tag;
   logic        mshr_load_addr, mshr_load_word, mshr_load_line;
   logic        mshr_port_index, mshr_inc_cur_ptr;
   logic        pmem_read, pmem_write, pmem_resp;
   logic [15:0] pmem_address;

   mshr_ctrl #(.DEPTH(16), .CNT_W(5)) dut (
      .clk              (clk),
      .reset            (reset),
      .port_req         (port_req),
      .port_write       (port_write),
      .port_resp        (port_resp),
      .mshr_full        (mshr_full),
      .mshr_dirty       (mshr_dirty),
      .mshr_waiting     (mshr_waiting),
      .mshr_addr_hit    (mshr_addr_hit),
      .mshr_hit         (mshr_hit),
      .mshr_tag         (mshr_tag),
      .mshr_load_addr   (mshr_load_addr),
      .mshr_load_word   (mshr_load_word),
      .mshr_load_line   (mshr_load_line),
      .mshr_port_index  (mshr_port_index),
      .mshr_inc_cur_ptr (mshr_inc_cur_ptr),
      .pmem_read        (pmem_read),
      .pmem_write       (pmem_write),
      .pmem_address     (pmem_address),
      .pmem_resp        (pmem_resp)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int mdl_cnt;

   typedef struct {
      logic [1:0] req, wr, ahit, hit;
      logic       full, dirty, waiting, presp;
      logic [1:0] resp;
      logic       la, lw, ll, pidx, inc, prd, pwr;
      logic [4:0] cnt;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic [1:0] req, input logic [1:0] wr,
                      input logic [1:0] ahit, input logic [1:0] hit,
                      input logic full, input logic dirty,
                      input logic waiting, input logic presp,
                      input logic [1:0] resp, input logic la, input logic lw,
                      input logic ll, input logic pidx, input logic inc,
                      input logic prd, input logic pwr, input logic [4:0] cnt);
      vec_t v;
      v.req = req;   v.wr = wr;       v.ahit = ahit;       v.hit = hit;
      v.full = full; v.dirty = dirty; v.waiting = waiting; v.presp = presp;
      v.resp = resp; v.la = la;       v.lw = lw;           v.ll = ll;
      v.pidx = pidx; v.inc = inc;     v.prd = prd;         v.pwr = pwr;
      v.cnt = cnt;
      vq.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [8:0] ctl_now();
      return {port_resp, mshr_load_addr, mshr_load_word, mshr_load_line,
              mshr_port_index, mshr_inc_cur_ptr, pmem_read, pmem_write};
   endfunction

   task automatic zero_inputs();
      port_req = 2'b00; port_write = 2'b00;
      mshr_full = 1'b0; mshr_dirty = 1'b0; mshr_waiting = 1'b0;
      mshr_addr_hit = 2'b00; mshr_hit = 2'b00; pmem_resp = 1'b0;
      mshr_tag = TAG;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [8:0]  exp_ctl;
      logic [15:0] exp_addr;

      reset = 1'b1;
      zero_inputs();

      // Columns: req wr ahit hit | full dirty waiting presp |
      //          resp la lw ll pidx inc prd pwr | count
      // A: read miss on port 1, 2-cycle pmem, clean line
      add(2'b10,2'b00,2'b00,2'b00, 0,0,1,0, 2'b00,1,0,0,1,0,0,0, 0);
      add(2'b10,2'b00,2'b10,2'b00, 0,0,1,0, 2'b00,0,0,0,0,0,0,0, 1);
      add(2'b10,2'b00,2'b10,2'b00, 0,0,1,0, 2'b00,0,0,0,0,0,1,0, 1);
      add(2'b10,2'b00,2'b10,2'b00, 0,0,1,1, 2'b00,0,0,0,0,0,1,0, 1);
      add(2'b10,2'b00,2'b10,2'b00, 0,0,1,0, 2'b00,0,0,1,0,0,0,0, 1);
      add(2'b10,2'b00,2'b10,2'b10, 0,0,1,0, 2'b10,0,0,0,0,1,0,0, 1);
      add(2'b00,2'b00,2'b00,2'b00, 0,0,1,0, 2'b00,0,0,0,0,0,0,0, 0);
      add(2'b00,2'b00,2'b00,2'b00, 0,0,1,0, 2'b00,0,0,0,0,0,0,0, 0);
      // B: both ports write misses for 3 cycles, then fill + write-back
      add(2'b11,2'b11,2'b00,2'b00, 0,1,1,0, 2'b01,0,1,0,0,0,0,0, 0);
      add(2'b11,2'b11,2'b00,2'b00, 0,1,1,0, 2'b10,0,1,0,1,0,0,0, 1);
      add(2'b11,2'b11,2'b00,2'b00, 0,1,1,0, 2'b01,0,1,0,0,0,1,0, 2);
      add(2'b00,2'b00,2'b00,2'b00, 0,1,1,1, 2'b00,0,0,0,0,0,1,0, 3);
      add(2'b00,2'b00,2'b00,2'b00, 0,1,1,0, 2'b00,0,0,1,0,0,0,0, 3);
      add(2'b00,2'b00,2'b00,2'b00, 0,1,1,1, 2'b00,0,0,0,0,0,0,1, 3);
      add(2'b00,2'b00,2'b00,2'b00, 0,1,1,0, 2'b00,0,0,0,0,1,0,0, 3);
      add(2'b00,2'b00,2'b00,2'b00, 0,1,1,0, 2'b00,0,0,0,0,0,0,0, 2);
      // C: port 0 write hit granted in FILL, stalled through WB/RETIRE
      add(2'b01,2'b01,2'b01,2'b00, 0,1,1,1, 2'b01,0,1,0,0,0,1,0, 2);
      add(2'b01,2'b01,2'b01,2'b00, 0,1,1,0, 2'b00,0,0,1,0,0,0,0, 2);
      add(2'b01,2'b01,2'b01,2'b00, 0,1,1,0, 2'b00,0,0,0,0,0,0,1, 2);
      add(2'b01,2'b01,2'b01,2'b00, 0,1,1,1, 2'b00,0,0,0,0,0,0,1, 2);
      add(2'b01,2'b01,2'b01,2'b00, 0,1,1,0, 2'b00,0,0,0,0,1,0,0, 2);
      add(2'b01,2'b01,2'b01,2'b00, 0,0,0,0, 2'b01,0,1,0,0,0,0,0, 1);
      add(2'b00,2'b00,2'b00,2'b00, 0,0,0,0, 2'b00,0,0,0,0,1,0,0, 1);
      add(2'b00,2'b00,2'b00,2'b00, 0,0,0,0, 2'b00,0,0,0,0,0,0,0, 0);
      // D: request during load_line waits one cycle; read-hit response
      add(2'b01,2'b00,2'b00,2'b00, 0,0,1,0, 2'b00,1,0,0,0,0,0,0, 0);
      add(2'b00,2'b00,2'b00,2'b00, 0,0,1,0, 2'b00,0,0,0,0,0,0,0, 1);
      add(2'b00,2'b00,2'b00,2'b00, 0,0,1,1, 2'b00,0,0,0,0,0,1,0, 1);
      add(2'b10,2'b10,2'b00,2'b00, 0,1,1,0, 2'b00,0,0,1,0,0,0,0, 1);
      add(2'b10,2'b10,2'b00,2'b00, 0,1,1,1, 2'b10,0,1,0,1,0,0,1, 1);
      add(2'b00,2'b00,2'b00,2'b00, 0,1,1,0, 2'b00,0,0,0,0,1,0,0, 2);
      add(2'b01,2'b00,2'b01,2'b01, 0,0,0,0, 2'b01,0,0,0,0,0,0,0, 1);
      add(2'b00,2'b00,2'b00,2'b00, 0,0,0,0, 2'b00,0,0,0,0,1,0,0, 1);
      add(2'b00,2'b00,2'b00,2'b00, 0,0,0,0, 2'b00,0,0,0,0,0,0,0, 0);
      // E: preference held across single grants -> port 1 wins now
      add(2'b11,2'b11,2'b00,2'b00, 0,0,0,0, 2'b10,0,1,0,1,0,0,0, 0);
      add(2'b00,2'b00,2'b00,2'b00, 0,0,0,0, 2'b00,0,0,0,0,0,0,0, 1);
      add(2'b00,2'b00,2'b00,2'b00, 0,0,0,0, 2'b00,0,0,0,0,1,0,0, 1);
      add(2'b00,2'b00,2'b00,2'b00, 0,0,0,0, 2'b00,0,0,0,0,0,0,0, 0);

      // Reset state
      @(negedge clk);
      #2;
      chk("rst_ctl", 32'(ctl_now()), 32'd0);
      chk("rst_addr", 32'(pmem_address), 32'd0);
      chk("rst_count", 32'(dut.count_q), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Table-driven vectors, one per clock
      for (int i = 0; i < vq.size(); i++) begin
         port_req      = vq[i].req;
         port_write    = vq[i].wr;
         mshr_addr_hit = vq[i].ahit;
         mshr_hit      = vq[i].hit;
         mshr_full     = vq[i].full;
         mshr_dirty    = vq[i].dirty;
         mshr_waiting  = vq[i].waiting;
         pmem_resp     = vq[i].presp;
         #2;
         exp_ctl  = {vq[i].resp, vq[i].la, vq[i].lw, vq[i].ll, vq[i].pidx,
                     vq[i].inc, vq[i].prd, vq[i].pwr};
         exp_addr = (vq[i].prd | vq[i].pwr) ? ADDR : 16'h0000;
         chk($sformatf("vec%0d_ctl", i),   32'(ctl_now()),    32'(exp_ctl));
         chk($sformatf("vec%0d_addr", i),  32'(pmem_address), 32'(exp_addr));
         chk($sformatf("vec%0d_count", i), 32'(dut.count_q),  32'(vq[i].cnt));
         @(negedge clk);
      end

      // Fill 15 entries with pmem stalled; full blocks the 16th
      reset = 1'b1;
      zero_inputs();
      @(negedge clk);
      reset = 1'b0;
      mdl_cnt = 0;
      for (int i = 0; i < 15; i++) begin
         port_req = 2'b10; port_write = 2'b00; mshr_addr_hit = 2'b00;
         mshr_waiting = 1'b1; mshr_dirty = 1'b0; pmem_resp = 1'b0;
         mshr_full = (mdl_cnt >= 15);
         #2;
         chk($sformatf("fill_alloc%0d", i), 32'(mshr_load_addr), 32'd1);
         @(negedge clk);
         mdl_cnt++;
      end
      #2;
      chk("fill_count15", 32'(dut.count_q), 32'(mdl_cnt));
      mshr_full = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #2;
         chk($sformatf("full_block%0d", i), 32'(mshr_load_addr), 32'd0);
         @(negedge clk);
      end
      pmem_resp = 1'b1;
      #2;
      chk("full_fill_read", 32'(pmem_read), 32'd1);
      @(negedge clk);
      pmem_resp = 1'b0; mshr_waiting = 1'b0;
      #2;
      chk("full_load_line", 32'({mshr_load_line, mshr_load_addr}), 32'b10);
      @(negedge clk);
      #2;
      chk("full_retire", 32'({mshr_inc_cur_ptr, mshr_load_addr}), 32'b10);
      @(negedge clk);
      mdl_cnt--;
      mshr_full = (mdl_cnt >= 15);
      #2;
      chk("full_realloc", 32'({mshr_load_addr, mshr_port_index}), 32'b11);
      @(negedge clk);
      mdl_cnt++;
      port_req = 2'b00;
      #2;
      chk("full_count_after", 32'(dut.count_q), 32'(mdl_cnt));

      // Reset while write-back is in flight
      reset = 1'b1;
      zero_inputs();
      @(negedge clk);
      reset = 1'b0;
      port_req = 2'b01; port_write = 2'b01; mshr_dirty = 1'b1;
      #2;
      chk("wbrst_grant", 32'({port_resp, mshr_load_word}), 32'b011);
      @(negedge clk);
      port_req = 2'b00; port_write = 2'b00;
      @(negedge clk);
      #2;
      chk("wbrst_pwrite", 32'({pmem_write, pmem_address}), 32'({1'b1, ADDR}));
      #1;
      reset = 1'b1;
      #1;
      chk("wbrst_async_ctl", 32'(ctl_now()), 32'd0);
      @(negedge clk);
      chk("wbrst_ctl", 32'(ctl_now()), 32'd0);
      chk("wbrst_count", 32'(dut.count_q), 32'd0);
      chk("wbrst_state", 32'(dut.state_q), 32'd0);
      reset = 1'b0;
      #2;
      chk("wbrst_idle_after", 32'(ctl_now()), 32'd0);
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
